// File: rtl/method_select_input.sv
// Push-button front end for the method selector: synchronise and debounce three buttons,
// step a method index through NUM_METHODS values, and hand a confirmed choice to the controller.
module method_select_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_METHODS     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       enable,
    input  logic       method_ack,
    output logic [2:0] method_sel,
    output logic       method_valid,
    output logic       busy,
    output logic [1:0] fsm_state
);

    localparam int              CW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      LAST    = 3'(NUM_METHODS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t state;

    // Bit order for all per-button vectors: 0 = next, 1 = prev, 2 = confirm.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    pulse;
    logic [CW-1:0] cnt [3];

    assign raw       = {btn_confirm, btn_prev, btn_next};
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            pulse    <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            // Rising edge of the debounced level, one cycle after it settles.
            pulse    <= stable & ~stable_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            method_sel   <= '0;
            method_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= SELECT;
                end
                SELECT: begin
                    // Enable drop beats confirm, which beats a same-cycle next/prev.
                    if (!enable) begin
                        state <= IDLE;
                    end else if (pulse[2]) begin
                        method_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= HOLD;
                    end else if (pulse[0] && !pulse[1]) begin
                        method_sel <= (method_sel == LAST) ? 3'd0 : method_sel + 3'd1;
                    end else if (pulse[1] && !pulse[0]) begin
                        method_sel <= (method_sel == 3'd0) ? LAST : method_sel - 3'd1;
                    end
                end
                HOLD: begin
                    if (method_ack) begin
                        method_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= enable ? SELECT : IDLE;
                    end else if (!enable) begin
                        method_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    method_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_method_select_input.sv
// Directed bench for method_select_input with a short debounce window.
module tb_method_select_input;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_confirm;
    logic       enable;
    logic       method_ack;
    logic [2:0] method_sel;
    logic       method_valid;
    logic       busy;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    method_select_input #(
        .DEBOUNCE_CYCLES(DB),
        .NUM_METHODS    (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .btn_confirm (btn_confirm),
        .enable      (enable),
        .method_ack  (method_ack),
        .method_sel  (method_sel),
        .method_valid(method_valid),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge for driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sample at the falling edge so outputs have settled.
    task automatic sample;
        @(negedge clk);
    endtask

    // Press-and-release: which bits 0=next 1=prev 2=confirm.
    task automatic press(input logic [2:0] which);
        btn_next    = which[0];
        btn_prev    = which[1];
        btn_confirm = which[2];
        step(10);
        btn_next    = 1'b0;
        btn_prev    = 1'b0;
        btn_confirm = 1'b0;
        step(10);
    endtask

    initial begin
        rst = 1'b1; btn_next = 0; btn_prev = 0; btn_confirm = 0;
        enable = 0; method_ack = 0;
        step(3);
        sample;
        check("reset_sel", method_sel, 0);
        check("reset_valid", method_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_state", fsm_state, 0);

        step(1);
        rst = 1'b0;
        enable = 1'b1;
        step(2);
        sample;
        check("enter_select", fsm_state, 1);

        step(0);
        press(3'b001); sample; check("next_1", method_sel, 1);
        press(3'b001); sample; check("next_2", method_sel, 2);
        press(3'b001); sample; check("next_3", method_sel, 3);
        check("no_valid_while_selecting", method_valid, 0);

        press(3'b001); sample; check("next_4", method_sel, 4);
        press(3'b001); sample; check("wrap_up", method_sel, 0);
        press(3'b010); sample; check("wrap_down", method_sel, 4);
        press(3'b010); sample; check("prev_to_3", method_sel, 3);

        // Three-cycle glitch is rejected.
        step(0);
        btn_next = 1'b1;
        step(3);
        btn_next = 1'b0;
        step(15);
        sample;
        check("glitch_rejected", method_sel, 3);

        // Held for 8 cycles: change appears exactly DB+4 edges after the raw rise.
        step(0);
        btn_next = 1'b1;
        step(DB + 3);
        sample;
        check("latency_before", method_sel, 3);
        step(1);
        sample;
        check("latency_at", method_sel, 4);
        step(0);
        btn_next = 1'b1;
        step(8 - (DB + 4));
        btn_next = 1'b0;
        step(15);
        sample;
        check("single_increment", method_sel, 4);

        step(0);
        press(3'b010); press(3'b010);
        sample; check("back_to_2", method_sel, 2);

        // Confirm handshake.
        step(0);
        method_ack = 1'b1;
        step(1);
        method_ack = 1'b0;
        step(1);
        sample;
        check("ack_outside_hold_valid", method_valid, 0);
        check("ack_outside_hold_state", fsm_state, 1);
        step(0);
        press(3'b100);
        sample;
        check("confirm_valid", method_valid, 1);
        check("confirm_busy", busy, 1);
        check("confirm_state", fsm_state, 2);
        step(0);
        press(3'b001);
        sample;
        check("hold_frozen_sel", method_sel, 2);
        check("hold_valid_kept", method_valid, 1);
        step(0);
        method_ack = 1'b1;
        step(1);
        method_ack = 1'b0;
        sample;
        check("ack_valid", method_valid, 0);
        check("ack_busy", busy, 0);
        check("ack_state", fsm_state, 1);
        step(0);
        press(3'b001);
        sample;
        check("next_after_ack", method_sel, 3);

        // Simultaneous events.
        step(0);
        press(3'b011);
        sample; check("next_prev_cancel", method_sel, 3);
        step(0);
        press(3'b010); press(3'b010);
        sample; check("down_to_1", method_sel, 1);
        step(0);
        press(3'b101);
        sample;
        check("next_confirm_valid", method_valid, 1);
        check("next_confirm_sel", method_sel, 1);
        step(0);
        method_ack = 1'b1;
        step(1);
        method_ack = 1'b0;
        sample;
        check("ack2_valid", method_valid, 0);

        // Enable low: presses ignored.
        step(0);
        enable = 1'b0;
        step(1);
        sample;
        check("disable_idle", fsm_state, 0);
        step(0);
        press(3'b001);
        sample;
        check("disabled_next_ignored", method_sel, 1);
        check("disabled_still_idle", fsm_state, 0);

        // Enable drop during HOLD aborts.
        step(0);
        enable = 1'b1;
        press(3'b100);
        sample;
        check("hold_again", fsm_state, 2);
        step(0);
        enable = 1'b0;
        step(1);
        sample;
        check("abort_valid", method_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_state", fsm_state, 0);

        // Reset mid-HOLD.
        step(0);
        enable = 1'b1;
        press(3'b100);
        sample;
        check("hold_before_rst", method_valid, 1);
        step(0);
        rst = 1'b1;
        step(1);
        sample;
        check("rst_sel", method_sel, 0);
        check("rst_valid", method_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_state", fsm_state, 0);
        step(0);
        rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
